// File: rtl/tx_stream_mux.sv
// rtl/tx_stream_mux.sv - source-select stream mux with gain and glitch-free switching; optional gain stage: TX_STREAM_MUX_GAIN_EN
module tx_stream_mux #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int NUM_CH         = 3,
  parameter int SAMPLE_W       = 16,
  parameter int SWITCH_GAP     = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_CH-1:0]                        s_tvalid,
  input  logic [NUM_CH*NUMBER_OF_LINE*SAMPLE_W-1:0] s_tdata_i,
  input  logic [NUM_CH*NUMBER_OF_LINE*SAMPLE_W-1:0] s_tdata_q,
  output logic [NUM_CH-1:0]                        s_tready,
  input  logic [7:0]                               output_select,
  input  logic [15:0]                              gain,
  output logic [2*NUMBER_OF_LINE*SAMPLE_W-1:0]     m_tdata,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [7:0]                               active_select,
  output logic                                     switch_busy,
  output logic [31:0]                              sat_count
);
  localparam int BEAT_W = NUMBER_OF_LINE * SAMPLE_W;
  localparam int OUT_W  = 2 * BEAT_W;

  typedef enum logic {ST_RUN, ST_GAP} state_t;

  state_t            state_q;
  logic [7:0]        active_q, pending_q;
  logic [7:0]        gap_cnt_q;
  logic              switch_busy_q;
  logic              en;

  logic              sel_real, sel_iq;
  logic [7:0]        sel_ch;
  logic [BEAT_W-1:0] src_i, src_q;
  logic              src_valid;

  logic              s1_valid_q, s1_valid_d;
  logic [BEAT_W-1:0] s1_i_q, s1_q_q, s1_i_d, s1_q_d;

  logic [OUT_W-1:0]  out_d, m_tdata_q;
  logic              out_valid_d, out_sat_d;
  logic              m_tvalid_q, m_sat_q;
  logic [31:0]       sat_count_q;

  assign en = !m_tvalid_q || m_tready;

  // Decode the active select into mode and channel index, and pick that channel's beat
  always_comb begin
    sel_real  = 1'b0;
    sel_iq    = 1'b0;
    sel_ch    = '0;
    src_i     = '0;
    src_q     = '0;
    src_valid = 1'b0;
    if (active_q >= 8'd1 && active_q <= 8'(NUM_CH)) begin
      sel_real = 1'b1;
      sel_ch   = active_q - 8'd1;
    end else if (active_q >= 8'(NUM_CH + 1) && active_q <= 8'(2 * NUM_CH)) begin
      sel_iq = 1'b1;
      sel_ch = active_q - 8'(NUM_CH + 1);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 8'(c)) begin
        src_i     = s_tdata_i[c*BEAT_W +: BEAT_W];
        src_q     = s_tdata_q[c*BEAT_W +: BEAT_W];
        src_valid = s_tvalid[c];
      end
    end
  end

  // Only the channel feeding S1 sees backpressure; everything else is drained freely
  always_comb begin
    s_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset)
        s_tready[c] = 1'b0;
      else if (state_q == ST_RUN && (sel_real || sel_iq) && sel_ch == 8'(c))
        s_tready[c] = en;
      else
        s_tready[c] = 1'b1;
    end
  end

  // S1 next beat: real keeps Q at zero, zero-select and the gap emit valid zero beats
  always_comb begin
    s1_i_d     = '0;
    s1_q_d     = '0;
    s1_valid_d = 1'b1;
    if (state_q == ST_RUN && (sel_real || sel_iq)) begin
      s1_i_d     = src_i;
      s1_valid_d = src_valid;
      if (sel_iq)
        s1_q_d = src_q;
    end
  end

  // Switch FSM: a select change opens a gap of SWITCH_GAP zero beats, restarted by further changes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      active_q      <= '0;
      pending_q     <= '0;
      gap_cnt_q     <= '0;
      switch_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (output_select != active_q) begin
            state_q       <= ST_GAP;
            pending_q     <= output_select;
            gap_cnt_q     <= '0;
            switch_busy_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (output_select != pending_q) begin
            pending_q <= output_select;
            gap_cnt_q <= '0;
          end else if (en) begin
            if (gap_cnt_q == 8'(SWITCH_GAP - 1)) begin
              state_q       <= ST_RUN;
              active_q      <= pending_q;
              switch_busy_q <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // S1 capture register
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
    end else if (en) begin
      s1_valid_q <= s1_valid_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
    end
  end

`ifdef TX_STREAM_MUX_GAIN_EN
  localparam int PROD_W = SAMPLE_W + 17;
  localparam logic signed [PROD_W-1:0] RND   = PROD_W'(8192);
  localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] MIN_V = -MAX_V - PROD_W'(1);

  logic [15:0]              s1_gain_q;
  logic                     s2_valid_q;
  logic signed [PROD_W-1:0] prod_i [NUMBER_OF_LINE];
  logic signed [PROD_W-1:0] prod_q [NUMBER_OF_LINE];
  logic signed [PROD_W-1:0] s2_pi_q [NUMBER_OF_LINE];
  logic signed [PROD_W-1:0] s2_pq_q [NUMBER_OF_LINE];
  logic [SAMPLE_W:0]        rs_i, rs_q;

  // Round half up at bit 13, shift back to sample scale, clamp; MSB of the result flags a clamp
  function automatic logic [SAMPLE_W:0] rnd_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] r;
    r = (p + RND) >>> 14;
    if (r > MAX_V)
      rnd_sat = {1'b1, MAX_V[SAMPLE_W-1:0]};
    else if (r < MIN_V)
      rnd_sat = {1'b1, MIN_V[SAMPLE_W-1:0]};
    else
      rnd_sat = {1'b0, r[SAMPLE_W-1:0]};
  endfunction

  // Gain travels with its beat through S1
  always_ff @(posedge clock) begin
    if (reset)
      s1_gain_q <= '0;
    else if (en)
      s1_gain_q <= gain;
  end

  // Signed sample times unsigned Q2.14 gain
  always_comb begin
    for (int k = 0; k < NUMBER_OF_LINE; k++) begin
      prod_i[k] = PROD_W'($signed(s1_i_q[k*SAMPLE_W +: SAMPLE_W])) * PROD_W'($signed({1'b0, s1_gain_q}));
      prod_q[k] = PROD_W'($signed(s1_q_q[k*SAMPLE_W +: SAMPLE_W])) * PROD_W'($signed({1'b0, s1_gain_q}));
    end
  end

  // S2 product register
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      for (int k = 0; k < NUMBER_OF_LINE; k++) begin
        s2_pi_q[k] <= '0;
        s2_pq_q[k] <= '0;
      end
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      for (int k = 0; k < NUMBER_OF_LINE; k++) begin
        s2_pi_q[k] <= prod_i[k];
        s2_pq_q[k] <= prod_q[k];
      end
    end
  end

  // S3 round/saturate and interleave I/Q per lane
  always_comb begin
    out_d       = '0;
    out_sat_d   = 1'b0;
    out_valid_d = s2_valid_q;
    rs_i        = '0;
    rs_q        = '0;
    for (int k = 0; k < NUMBER_OF_LINE; k++) begin
      rs_i = rnd_sat(s2_pi_q[k]);
      rs_q = rnd_sat(s2_pq_q[k]);
      out_d[(2*k)*SAMPLE_W +: SAMPLE_W]   = rs_i[SAMPLE_W-1:0];
      out_d[(2*k+1)*SAMPLE_W +: SAMPLE_W] = rs_q[SAMPLE_W-1:0];
      out_sat_d = out_sat_d | rs_i[SAMPLE_W] | rs_q[SAMPLE_W];
    end
  end
`else
  logic unused_gain;
  assign unused_gain = ^gain;

  // Unity gain: interleave S1 straight into the output register
  always_comb begin
    out_d       = '0;
    out_sat_d   = 1'b0;
    out_valid_d = s1_valid_q;
    for (int k = 0; k < NUMBER_OF_LINE; k++) begin
      out_d[(2*k)*SAMPLE_W +: SAMPLE_W]   = s1_i_q[k*SAMPLE_W +: SAMPLE_W];
      out_d[(2*k+1)*SAMPLE_W +: SAMPLE_W] = s1_q_q[k*SAMPLE_W +: SAMPLE_W];
    end
  end
`endif

  // Output register and saturating clip counter over accepted beats
  always_ff @(posedge clock) begin
    if (reset) begin
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_sat_q     <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (en) begin
        m_tvalid_q <= out_valid_d;
        m_tdata_q  <= out_d;
        m_sat_q    <= out_sat_d && out_valid_d;
      end
      if (m_tvalid_q && m_tready && m_sat_q && sat_count_q != 32'hFFFF_FFFF)
        sat_count_q <= sat_count_q + 32'd1;
    end
  end

  assign m_tdata       = m_tdata_q;
  assign m_tvalid      = m_tvalid_q;
  assign active_select = active_q;
  assign switch_busy   = switch_busy_q;
  assign sat_count     = sat_count_q;

endmodule
